// File: rtl/gray_coder_pkg.sv
// gray_coder_pkg: shared width default and binary/Gray conversion helpers for gray_coder.
package gray_coder_pkg;

    localparam int GRAY_WIDTH_DEFAULT = 4;
    localparam int GRAY_WIDTH_MAX = 32;

    function automatic logic [GRAY_WIDTH_MAX-1:0] bin2gray(input logic [GRAY_WIDTH_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Narrower codes are zero-extended, so the leading zeros leave the prefix XOR unchanged.
    function automatic logic [GRAY_WIDTH_MAX-1:0] gray2bin(input logic [GRAY_WIDTH_MAX-1:0] g);
        logic [GRAY_WIDTH_MAX-1:0] b;
        b[GRAY_WIDTH_MAX-1] = g[GRAY_WIDTH_MAX-1];
        for (int i = GRAY_WIDTH_MAX - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/gray_decode.sv
// gray_decode: combinational Gray-to-binary XOR prefix chain.
module gray_decode
    import gray_coder_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the parity of its Gray bit and every Gray bit above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_coder.sv
// gray_coder: combinational binary-to-Gray encode, registered Gray-to-binary decode.
// Defining GRAY_CODER_CHECK_EN adds a registered single-bit-step checker on step_err.
module gray_coder
    import gray_coder_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bin_in,
    output logic [WIDTH-1:0] gray_out,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] bin_out,
    output logic             out_valid
`ifdef GRAY_CODER_CHECK_EN
    ,
    output logic             step_err
`endif
);

    logic [WIDTH-1:0] dec_bin;

    assign gray_out = WIDTH'(bin2gray(GRAY_WIDTH_MAX'(bin_in)));

    gray_decode #(.WIDTH(WIDTH)) u_decode (
        .gray (gray_in),
        .bin  (dec_bin)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) bin_out <= dec_bin;
        end
    end

`ifdef GRAY_CODER_CHECK_EN
    logic [WIDTH-1:0] prev_gray;
    logic             have_prev;
    logic [WIDTH-1:0] diff;
    logic             one_step;

    // Exactly one differing bit: nonzero and a power of two.
    assign diff     = gray_in ^ prev_gray;
    assign one_step = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_gray <= '0;
            have_prev <= 1'b0;
            step_err  <= 1'b0;
        end else begin
            step_err <= in_valid && have_prev && !one_step;
            if (in_valid) begin
                prev_gray <= gray_in;
                have_prev <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gray_coder.sv
// tb_gray_coder: randomized and directed checks of gray_coder against a table-based reference model.
module tb_gray_coder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] bin_in = '0;
    logic [W-1:0] gray_in = '0;
    logic [W-1:0] gray_out;
    logic [W-1:0] bin_out;
    logic         out_valid;
`ifdef GRAY_CODER_CHECK_EN
    logic         step_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_bin = '0;
    logic         m_valid = 1'b0;
    logic         m_err = 1'b0;
    logic [W-1:0] m_prev = '0;
    logic         m_have = 1'b0;

    always #5 clk = ~clk;

    gray_coder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bin_in    (bin_in),
        .gray_out  (gray_out),
        .gray_in   (gray_in),
        .in_valid  (in_valid),
        .bin_out   (bin_out),
        .out_valid (out_valid)
`ifdef GRAY_CODER_CHECK_EN
        ,
        .step_err  (step_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decode by searching for the binary value whose arithmetic Gray code matches.
    function automatic logic [W-1:0] ref_dec(input logic [W-1:0] g);
        for (int b = 0; b < (1 << W); b++)
            if (W'(b ^ (b / 2)) == g) return W'(b);
        return '0;
    endfunction

    task automatic cycle(input bit r, input bit v, input logic [W-1:0] g, input string tag);
        @(negedge clk);
        rst = r;
        in_valid = v;
        gray_in = g;
        @(posedge clk);
        #1;
        if (r) begin
            m_bin = '0;
            m_valid = 1'b0;
            m_err = 1'b0;
            m_have = 1'b0;
        end else begin
            m_valid = v;
            m_err = v && m_have && ($countones(g ^ m_prev) != 1);
            if (v) begin
                m_bin = ref_dec(g);
                m_prev = g;
                m_have = 1'b1;
            end
        end
        check({tag, ".bin_out"}, 32'(bin_out), 32'(m_bin));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
`ifdef GRAY_CODER_CHECK_EN
        check({tag, ".step_err"}, 32'(step_err), 32'(m_err));
`endif
    endtask

    initial begin
        logic [W-1:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                   4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                   4'b1010, 4'b1011, 4'b1001, 4'b1000};
        cycle(1, 0, '0, "reset");
        cycle(1, 1, 4'b1010, "reset2");

        for (int i = 0; i < 16; i++) begin
            bin_in = W'(i);
            #1;
            check($sformatf("enc%0d", i), 32'(gray_out), 32'(gtab[i]));
        end

        cycle(0, 1, 4'b1101, "dec1101");
        check("dec1101.lit", 32'(bin_out), 32'b1001);
        cycle(0, 0, 4'b0000, "hold");
        check("hold.lit", 32'(bin_out), 32'b1001);
        cycle(0, 1, 4'b0110, "b2b_a");
        check("b2b_a.lit", 32'(bin_out), 32'b0100);
        cycle(0, 1, 4'b1100, "b2b_b");
        check("b2b_b.lit", 32'({out_valid, bin_out}), 32'b11000);
        cycle(1, 1, 4'b1111, "rst_wins");
        check("rst_wins.lit", 32'({out_valid, bin_out}), 32'b0);

`ifdef GRAY_CODER_CHECK_EN
        cycle(0, 1, 4'b1101, "adj_a");
        cycle(0, 1, 4'b1100, "adj_b");
        check("adj.lit", 32'(step_err), 32'b0);
        cycle(0, 1, 4'b1101, "far_a");
        cycle(0, 1, 4'b1010, "far_b");
        check("far.lit", 32'(step_err), 32'b1);
        cycle(0, 0, 4'b0000, "far_idle");
        check("far_idle.lit", 32'(step_err), 32'b0);
        cycle(0, 1, 4'b1000, "wrap_a");
        cycle(0, 1, 4'b0000, "wrap_b");
        check("wrap.lit", 32'(step_err), 32'b0);
        cycle(0, 1, 4'b0011, "rep_a");
        cycle(0, 1, 4'b0011, "rep_b");
        check("rep.lit", 32'(step_err), 32'b1);
        cycle(1, 0, 4'b0000, "rep_rst");
        cycle(0, 1, 4'b0101, "first");
        check("first.lit", 32'(step_err), 32'b0);
`endif

        // Random traffic: frequent single-bit steps so both checker outcomes occur.
        for (int n = 0; n < 300; n++) begin
            logic [W-1:0] g;
            bit v, r;
            r = ($urandom_range(0, 29) == 0);
            v = ($urandom_range(0, 3) != 0);
            g = ($urandom_range(0, 1) == 1) ? (m_prev ^ W'(1 << $urandom_range(0, W - 1))) : W'($urandom);
            bin_in = W'($urandom);
            #1;
            check("enc_rand", 32'(gray_out), 32'(bin_in ^ (bin_in / 2)));
            cycle(r, v, g, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_coder.md
# gray_coder

Binary/Gray code converter used wherever multi-bit counts or pointers cross into Gray representation. It has a zero-latency combinational binary-to-Gray encode path and a registered Gray-to-binary decode path with a valid strobe. An optional checker flags decoded Gray inputs that violate the single-bit-step property. The block is a leaf utility, instantiated beside counters and pointer logic.

## Interface
- `WIDTH`, default 4: code width in bits; legal range 2..32.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `bin_in`  in  WIDTH  binary value to encode.
- `gray_out`  out  WIDTH  Gray encoding of `bin_in`; combinational.
- `gray_in`  in  WIDTH  Gray value to decode.
- `in_valid`  in  1  qualifies `gray_in` this cycle.
- `bin_out`  out  WIDTH  registered binary decode of the last valid `gray_in`.
- `out_valid`  out  1  high for exactly one cycle, the cycle after an accepted `in_valid`.
- `step_err`  out  1  registered adjacency error flag; exists only with `GRAY_CODER_CHECK_EN`.

## Operation
- **Encode:** `gray_out = bin_in ^ (bin_in >> 1)`.
  - Purely combinational and unaffected by `clk` or `rst`.
  - All 2^WIDTH inputs are legal.
- **Decode:**
  - `b[WIDTH-1] = g[WIDTH-1]`.
  - `b[i] = b[i+1] ^ g[i]`, for i descending to 0.
- **Decode register update:**
  - When `in_valid` = 1, the decoded value loads into `bin_out` and `out_valid` goes to 1.
  - When `in_valid` = 0, `bin_out` holds its value and `out_valid` goes to 0.
- No backpressure: every valid input is accepted.
- Widths are exact: no sign extension and no carry.
- The encode and decode paths are independent. Simultaneous activity on both paths has no interaction.

## Timing
- Encode latency is 0 cycles.
- Decode latency is 1 cycle, at full throughput: back-to-back valid inputs give back-to-back `out_valid` pulses.
- Reset values: `bin_out` = 0, `out_valid` = 0, `step_err` = 0, and the checker history is cleared to "no previous sample".
- If `rst` is asserted in the same cycle as `in_valid`, reset wins and the input is dropped.
- Reset mid-stream discards the checker history. The first valid sample after reset never raises `step_err`.

## Configuration
- **With `GRAY_CODER_CHECK_EN` defined:**
  - The block registers the previous valid `gray_in` and the checker history.
  - On each valid input after the first, `step_err` is set for one cycle, aligned with `out_valid`, when the Hamming distance to the previous sample is not exactly 1.
  - A repeated value (distance 0) is an error.
  - Wrap-around (all-ones binary to 0, e.g. Gray 1000 -> 0000 for WIDTH = 4) is legal.
- **Without the macro:** `step_err` is absent from the port list and no checker logic is built.

## Structure
- Package `gray_coder_pkg` holds:
  - the default `WIDTH` constant;
  - functions `bin2gray` and `gray2bin`.
- One sub-module, `gray_decode`: a combinational WIDTH-bit XOR prefix chain. The top level registers its output.
- The checker stays in the top level under the macro guard.

## Test plan
- Sweep `bin_in` over 0..15 (WIDTH = 4) -> `gray_out` = 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000. Specifically, 0101 -> 0111 and 1010 -> 1111.
- Drive `gray_in` = 1101 with `in_valid` = 1 -> next cycle `bin_out` = 1001, `out_valid` = 1. Then drop `in_valid` -> `out_valid` = 0 and `bin_out` holds 1001.
- Drive back-to-back valid inputs 0110, 1100 -> `bin_out` = 0100, then 1000, on consecutive cycles with `out_valid` continuously high.
- Assert `rst` together with `in_valid` and `gray_in` = 1111 -> next cycle `bin_out` = 0, `out_valid` = 0.
- With `GRAY_CODER_CHECK_EN`:
  - 1101 then 1100 -> `step_err` = 0.
  - 1101 then 1010 -> `step_err` = 1 for one cycle.
  - 1000 then 0000 -> `step_err` = 0.
- With `GRAY_CODER_CHECK_EN`: 0011 then 0011 -> `step_err` = 1. Reset, then 0101 -> `step_err` = 0.
